// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between an Avalon-MM CPU slave and a text-renderer fetch port.
// Video is favoured, but a pending CPU access is guaranteed a slot after MAX_VID_RUN video grants.
module vram_arbiter #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 32,
  parameter int MAX_VID_RUN = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic [ADDR_W-1:0]   cpu_address,
  input  logic [DATA_W-1:0]   cpu_writedata,
  input  logic [DATA_W/8-1:0] cpu_byteenable,
  output logic [DATA_W-1:0]   cpu_readdata,
  output logic                cpu_waitrequest,
  input  logic                vid_req,
  input  logic [ADDR_W-1:0]   vid_addr,
  output logic                vid_ack,
  output logic [DATA_W-1:0]   vid_rdata,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we,
  output logic [DATA_W/8-1:0] ram_be,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam int RC_W = $clog2(MAX_VID_RUN + 1);
  localparam logic [RC_W-1:0] RUN_MAX = RC_W'(MAX_VID_RUN);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    V_ADDR = 3'd1,
    V_DATA = 3'd2,
    C_ADDR = 3'd3,
    C_DATA = 3'd4,
    C_WR   = 3'd5
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [RC_W-1:0]   run_cnt_r;
  logic              cpu_pend_s;
  logic              grant_vid_s;
  logic              grant_cpu_s;
  logic              vid_ack_r;
  logic              cpu_waitrequest_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic              ram_we_r;
  logic [BE_W-1:0]   ram_be_r;
  logic [DATA_W-1:0] ram_wdata_r;

  assign cpu_pend_s = cpu_read | cpu_write;

  // Next-state and grant decision; grants are only made from IDLE.
  always_comb begin
    state_nxt_s = state_r;
    grant_vid_s = 1'b0;
    grant_cpu_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (vid_req && (!cpu_pend_s || (run_cnt_r < RUN_MAX))) begin
          grant_vid_s = 1'b1;
          state_nxt_s = V_ADDR;
        end else if (cpu_pend_s) begin
          grant_cpu_s = 1'b1;
          // a simultaneous read+write strobe is serviced as a write
          state_nxt_s = cpu_write ? C_WR : C_ADDR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      V_ADDR:  state_nxt_s = V_DATA;
      V_DATA:  state_nxt_s = IDLE;
      C_ADDR:  state_nxt_s = C_DATA;
      C_DATA:  state_nxt_s = IDLE;
      C_WR:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register plus the state-decoded handshake outputs, registered from next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r           <= IDLE;
      vid_ack_r         <= 1'b0;
      cpu_waitrequest_r <= 1'b1;
    end else begin
      state_r           <= state_nxt_s;
      vid_ack_r         <= (state_nxt_s == V_DATA);
      cpu_waitrequest_r <= !((state_nxt_s == C_DATA) || (state_nxt_s == C_WR));
    end
  end

  // Consecutive video grants made while the CPU is kept waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt_r <= '0;
    end else if (state_r == IDLE) begin
      if (grant_cpu_s || !cpu_pend_s) begin
        run_cnt_r <= '0;
      end else if (grant_vid_s && (run_cnt_r < RUN_MAX)) begin
        run_cnt_r <= run_cnt_r + 1'b1;
      end
    end
  end

  // RAM command registers, loaded on the grant edge; write enable lasts exactly the C_WR cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr_r  <= '0;
      ram_we_r    <= 1'b0;
      ram_be_r    <= '0;
      ram_wdata_r <= '0;
    end else begin
      ram_we_r <= 1'b0;
      if (grant_vid_s) begin
        ram_addr_r <= vid_addr;
        ram_be_r   <= '1;
      end else if (grant_cpu_s) begin
        ram_addr_r <= cpu_address;
        if (cpu_write) begin
          ram_we_r    <= 1'b1;
          ram_be_r    <= cpu_byteenable;
          ram_wdata_r <= cpu_writedata;
        end else begin
          ram_be_r <= '1;
        end
      end
    end
  end

  assign vid_ack         = vid_ack_r;
  assign cpu_waitrequest = cpu_waitrequest_r;
  assign vid_rdata       = ram_rdata;
  assign cpu_readdata    = ram_rdata;
  assign ram_addr        = ram_addr_r;
  assign ram_we          = ram_we_r;
  assign ram_be          = ram_be_r;
  assign ram_wdata       = ram_wdata_r;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: per-cycle vector table plus hand sequences for
// starvation bound, reset mid-access and idle behaviour. Includes a behavioural RAM.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_read, cpu_write;
  logic [10:0] cpu_address;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic        vid_req;
  logic [10:0] vid_addr;
  logic        vid_ack;
  logic [31:0] vid_rdata;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:2047];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(11), .DATA_W(32), .MAX_VID_RUN(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Synchronous single-port RAM: read data one clock after the address is sampled.
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic        vreq;
    logic [10:0] vaddr;
    logic        rd;
    logic        wr;
    logic [10:0] caddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        e_ack;
    logic        e_wait;
    logic        e_we;
    logic [3:0]  e_be;
    logic [1:0]  dsel;   // 0 none, 1 vid_rdata, 2 cpu_readdata
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs [23];

  function automatic vec_t mk(logic vreq, logic [10:0] vaddr, logic rd, logic wr,
                              logic [10:0] caddr, logic [31:0] wdata, logic [3:0] be,
                              logic e_ack, logic e_wait, logic e_we, logic [3:0] e_be,
                              logic [1:0] dsel, logic [31:0] e_data);
    vec_t v;
    v.vreq = vreq; v.vaddr = vaddr; v.rd = rd; v.wr = wr; v.caddr = caddr;
    v.wdata = wdata; v.be = be; v.e_ack = e_ack; v.e_wait = e_wait; v.e_we = e_we;
    v.e_be = e_be; v.dsel = dsel; v.e_data = e_data;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acks_before, done_cyc, resumed, vbad, we_seen;
    logic [31:0] cpu_seen;

    for (int i = 0; i < 2048; i++) mem[i] <= 32'h0;
    mem[5] <= 32'h0041_0742;

    // vid read, cpu write/read, rd+wr as write, vid_req dropped mid-fetch, partial write
    vecs[0]  = mk(1'b1, 11'd5, 1'b0, 1'b0, 11'd0,  32'h0,         4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 32'h0);
    vecs[1]  = mk(1'b1, 11'd5, 1'b0, 1'b0, 11'd0,  32'h0,         4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 2'd1, 32'h0041_0742);
    vecs[2]  = mk(1'b0, 11'd0, 1'b0, 1'b0, 11'd0,  32'h0,         4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 32'h0);
    vecs[3]  = mk(1'b0, 11'd0, 1'b0, 1'b1, 11'd9,  32'hDEAD_BEEF, 4'h3, 1'b0, 1'b0, 1'b1, 4'h3, 2'd0, 32'h0);
    vecs[4]  = mk(1'b0, 11'd0, 1'b0, 1'b1, 11'd9,  32'hDEAD_BEEF, 4'h3, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 32'h0);
    vecs[5]  = mk(1'b0, 11'd0, 1'b1, 1'b0, 11'd9,  32'h0,         4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 32'h0);
    vecs[6]  = mk(1'b0, 11'd0, 1'b1, 1'b0, 11'd9,  32'h0,         4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 2'd2, 32'h0000_BEEF);
    vecs[7]  = mk(1'b0, 11'd0, 1'b1, 1'b0, 11'd9,  32'h0,         4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 32'h0);
    vecs[8]  = mk(1'b0, 11'd0, 1'b0, 1'b0, 11'd0,  32'h0,         4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 32'h0);
    vecs[9]  = mk(1'b0, 11'd0, 1'b1, 1'b1, 11'd12, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 1'b1, 4'hF, 2'd0, 32'h0);
    vecs[10] = mk(1'b0, 11'd0, 1'b1, 1'b1, 11'd12, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 32'h0);
    vecs[11] = mk(1'b0, 11'd0, 1'b1, 1'b0, 11'd12, 32'h0,         4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 32'h0);
    vecs[12] = mk(1'b0, 11'd0, 1'b1, 1'b0, 11'd12, 32'h0,         4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 2'd2, 32'h1234_5678);
    vecs[13] = mk(1'b0, 11'd0, 1'b1, 1'b0, 11'd12, 32'h0,         4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 32'h0);
    vecs[14] = mk(1'b0, 11'd0, 1'b0, 1'b0, 11'd0,  32'h0,         4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 32'h0);
    vecs[15] = mk(1'b1, 11'd12, 1'b0, 1'b0, 11'd0, 32'h0,         4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 32'h0);
    vecs[16] = mk(1'b0, 11'd0, 1'b0, 1'b0, 11'd0,  32'h0,         4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 2'd1, 32'h1234_5678);
    vecs[17] = mk(1'b0, 11'd0, 1'b0, 1'b0, 11'd0,  32'h0,         4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 32'h0);
    vecs[18] = mk(1'b0, 11'd0, 1'b0, 1'b1, 11'd9,  32'h1122_3344, 4'hC, 1'b0, 1'b0, 1'b1, 4'hC, 2'd0, 32'h0);
    vecs[19] = mk(1'b0, 11'd0, 1'b0, 1'b1, 11'd9,  32'h1122_3344, 4'hC, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 32'h0);
    vecs[20] = mk(1'b0, 11'd0, 1'b1, 1'b0, 11'd9,  32'h0,         4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 32'h0);
    vecs[21] = mk(1'b0, 11'd0, 1'b1, 1'b0, 11'd9,  32'h0,         4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 2'd2, 32'h1122_BEEF);
    vecs[22] = mk(1'b0, 11'd0, 1'b1, 1'b0, 11'd9,  32'h0,         4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 32'h0);

    reset_n = 1'b1;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = 11'd0;
    cpu_writedata = 32'h0; cpu_byteenable = 4'h0;
    vid_req = 1'b0; vid_addr = 11'd0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_wait",  {31'd0, cpu_waitrequest}, 32'd1);
    check("rst_ack",   {31'd0, vid_ack}, 32'd0);
    check("rst_we",    {31'd0, ram_we}, 32'd0);
    check("rst_be",    {28'd0, ram_be}, 32'd0);
    check("rst_addr",  {21'd0, ram_addr}, 32'd0);
    check("rst_wdata", ram_wdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    tick();

    for (int i = 0; i < 23; i++) begin
      vid_req = vecs[i].vreq; vid_addr = vecs[i].vaddr;
      cpu_read = vecs[i].rd; cpu_write = vecs[i].wr; cpu_address = vecs[i].caddr;
      cpu_writedata = vecs[i].wdata; cpu_byteenable = vecs[i].be;
      tick();
      check($sformatf("v%0d_ack", i),  {31'd0, vid_ack}, {31'd0, vecs[i].e_ack});
      check($sformatf("v%0d_wait", i), {31'd0, cpu_waitrequest}, {31'd0, vecs[i].e_wait});
      check($sformatf("v%0d_we", i),   {31'd0, ram_we}, {31'd0, vecs[i].e_we});
      if (vecs[i].e_we) check($sformatf("v%0d_be", i), {28'd0, ram_be}, {28'd0, vecs[i].e_be});
      if (vecs[i].dsel == 2'd1) check($sformatf("v%0d_vdata", i), vid_rdata, vecs[i].e_data);
      if (vecs[i].dsel == 2'd2) check($sformatf("v%0d_cdata", i), cpu_readdata, vecs[i].e_data);
    end
    cpu_read = 1'b0; cpu_write = 1'b0;
    tick();

    // Starvation bound: 4 video acks, CPU granted on cycle 13 (data on 14), then video resumes.
    vid_req = 1'b1; vid_addr = 11'd5; cpu_read = 1'b1; cpu_address = 11'd9;
    acks_before = 0; done_cyc = 0; resumed = 0; vbad = 0; cpu_seen = 32'h0;
    for (int c = 1; c <= 40 && resumed == 0; c++) begin
      tick();
      if (vid_ack) begin
        if (vid_rdata !== 32'h0041_0742) vbad++;
        if (done_cyc == 0) acks_before++;
        else begin
          resumed = 1;
          vid_req = 1'b0;
        end
      end
      if (!cpu_waitrequest) begin
        done_cyc = c;
        cpu_seen = cpu_readdata;
        cpu_read = 1'b0;
      end
    end
    vid_req = 1'b0; cpu_read = 1'b0;
    check("starve_acks",    acks_before, 32'd4);
    check("starve_cpu_cyc", done_cyc, 32'd14);
    check("starve_cpu_dat", cpu_seen, 32'h1122_BEEF);
    check("starve_resume",  resumed, 32'd1);
    check("starve_vdata",   vbad, 32'd0);
    tick();

    // Reset asserted while a CPU read sits in C_ADDR.
    cpu_read = 1'b1; cpu_address = 11'd9;
    tick();
    check("rmid_caddr_wait", {31'd0, cpu_waitrequest}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rmid_wait", {31'd0, cpu_waitrequest}, 32'd1);
    check("rmid_we",   {31'd0, ram_we}, 32'd0);
    check("rmid_ack",  {31'd0, vid_ack}, 32'd0);
    cpu_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    vid_req = 1'b1; vid_addr = 11'd12;
    tick();
    check("rpost_ack0", {31'd0, vid_ack}, 32'd0);
    tick();
    check("rpost_ack1", {31'd0, vid_ack}, 32'd1);
    check("rpost_data", vid_rdata, 32'h1234_5678);
    vid_req = 1'b0;
    tick();

    // Idle for 10 cycles: nothing may move.
    we_seen = 0; vbad = 0; resumed = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ram_we) we_seen++;
      if (vid_ack) vbad++;
      if (!cpu_waitrequest) resumed++;
    end
    check("idle_we",   we_seen, 32'd0);
    check("idle_ack",  vbad, 32'd0);
    check("idle_wait", resumed, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- ADDR_W, 11, VRAM word address width (2400 chars, 2 per 32-bit word).
- DATA_W, 32, VRAM word width.
- MAX_VID_RUN, 4, maximum consecutive video grants while a CPU request is pending.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- cpu_read, in, 1, Avalon-MM read strobe.
- cpu_write, in, 1, Avalon-MM write strobe.
- cpu_address, in, ADDR_W, CPU word address.
- cpu_writedata, in, DATA_W, CPU write data.
- cpu_byteenable, in, DATA_W/8, CPU byte lanes.
- cpu_readdata, out, DATA_W, CPU read data.
- cpu_waitrequest, out, 1, Avalon-MM stall.
- vid_req, in, 1, text renderer fetch request, held until vid_ack.
- vid_addr, in, ADDR_W, fetch word address, stable while vid_req is high.
- vid_ack, out, 1, one-cycle fetch completion.
- vid_rdata, out, DATA_W, fetch data, valid while vid_ack is high.
- ram_addr, out, ADDR_W, single-port RAM address (registered).
- ram_we, out, 1, RAM write enable (registered).
- ram_be, out, DATA_W/8, RAM byte enables (registered).
- ram_wdata, out, DATA_W, RAM write data (registered).
- ram_rdata, in, DATA_W, RAM read data, valid one clock after address sampled.

Function
REQ-003 FSM states SHALL be IDLE, V_ADDR, V_DATA, C_ADDR, C_DATA, C_WR; exactly one RAM access SHALL be in flight at a time.

REQ-004 cpu_pend = cpu_read | cpu_write; in IDLE, video SHALL win if vid_req=1 and (cpu_pend=0 or run_cnt<MAX_VID_RUN); otherwise CPU SHALL win if cpu_pend=1; with neither request the FSM SHALL stay in IDLE.

REQ-005 Video grant: on the IDLE edge, ram_addr<=vid_addr and ram_we<=0; state IDLE->V_ADDR->V_DATA->IDLE.

REQ-006 vid_ack SHALL be 1 only in V_DATA, with vid_rdata=ram_rdata combinationally. Acceptance-to-ack latency is 2 cycles, and a new request is sampleable in the following IDLE cycle.

REQ-007 CPU read: ram_addr<=cpu_address, ram_we<=0; state IDLE->C_ADDR->C_DATA->IDLE. In C_DATA, cpu_waitrequest=0 and cpu_readdata=ram_rdata.

REQ-008 CPU write: ram_addr<=cpu_address, ram_wdata<=cpu_writedata, ram_be<=cpu_byteenable, ram_we<=1; state IDLE->C_WR->IDLE. ram_we SHALL be high only during C_WR, and cpu_waitrequest=0 in C_WR.

REQ-009 cpu_waitrequest SHALL be 1 in every state except C_DATA and C_WR.

REQ-010 If cpu_read and cpu_write are both 1, the access SHALL be treated as a write, and the read SHALL be ignored.

REQ-011 run_cnt (width clog2(MAX_VID_RUN+1)) rules:
- Increments on each video grant made while cpu_pend=1, saturating at MAX_VID_RUN.
- Clears on any CPU grant.
- Clears on any IDLE cycle with cpu_pend=0.

REQ-012 Worst-case CPU wait SHALL be MAX_VID_RUN*3+1 cycles from assertion to grant.

REQ-013 If vid_req drops mid-transaction, the access SHALL still complete, and vid_ack SHALL still pulse in V_DATA.

REQ-014 A CPU strobe removed before completion is illegal (Avalon hold rule), and no behaviour is specified for it.

REQ-015 ram_be SHALL be all-ones for reads.

Reset
REQ-016 reset_n=0 SHALL asynchronously force the following:
- state=IDLE, run_cnt=0.
- ram_addr=0, ram_we=0, ram_be=0, ram_wdata=0.
- vid_ack=0, cpu_waitrequest=1.
- vid_rdata and cpu_readdata=ram_rdata, don't-care.

REQ-017 Reset asserted mid-access SHALL abort the access, and no ram_we pulse SHALL appear after reset is released.

REQ-018 The first grant SHALL occur no earlier than the first rising edge after reset_n deasserts.

Verification
REQ-019 Video read: RAM[5]=0x00410742; vid_req=1, vid_addr=5 -> vid_ack high 2 cycles after acceptance, vid_rdata=0x00410742, ram_we=0 throughout.

REQ-020 CPU write then read:
- Write 0xDEADBEEF, byteenable=4'b0011, to addr 9 (RAM[9] previously 0).
- Expect one ram_we cycle with ram_be=4'b0011.
- A subsequent read of addr 9 returns 0x0000BEEF with one waitrequest=0 cycle.

REQ-021 Starvation bound: vid_req held continuously with cpu_read asserted, MAX_VID_RUN=4 -> exactly 4 video acks, then the CPU read completes, then video resumes; CPU wait <=13 cycles.

REQ-022 Simultaneous cpu_read=cpu_write=1 -> treated as a write: ram_we pulses, RAM is updated, and there is no C_DATA cycle.

REQ-023 Reset during C_ADDR -> state IDLE, cpu_waitrequest=1, ram_we=0 immediately; a fresh video request after release is acked with 2-cycle latency.

REQ-024 Idle: no requests for 10 cycles -> ram_we=0, vid_ack=0, cpu_waitrequest=1, run_cnt=0.
